// File: rtl/datapath_pipe_if.sv
// Instruction-issue and memory bus of datapath_pipe. The datapath uses the
// master modport; the control unit and RAM side of the bench uses slave.
interface datapath_pipe_if #(
  parameter int DATA_W = 32,
  parameter int RI     = 5,
  parameter int ADDR_W = 10,
  parameter int PC_W   = 32
);
  // Instruction handshake: fields are taken on a rising edge where instr_valid
  // and instr_ready are both high. Memory: mem_req and the address/data/we stay
  // stable until the edge on which mem_ack is high, which ends the request.
  logic              instr_valid;
  logic              instr_ready;
  logic [3:0]        alucode;
  logic [RI-1:0]     rd;
  logic [RI-1:0]     rs1;
  logic [RI-1:0]     rs2;
  logic [RI-1:0]     rs3;
  logic [DATA_W-1:0] imm;
  logic              imControl;
  logic              regenable;
  logic [1:0]        writecode;
  logic [1:0]        memop;
  logic [2:0]        pcControl;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic [PC_W-1:0]   PC;
  logic              zero_flag;

  modport master (
    input  instr_valid, alucode, rd, rs1, rs2, rs3, imm, imControl,
           regenable, writecode, memop, pcControl, mem_rdata, mem_ack,
    output instr_ready, mem_req, mem_we, mem_addr, mem_wdata, PC, zero_flag
  );

  modport slave (
    output instr_valid, alucode, rd, rs1, rs2, rs3, imm, imControl,
           regenable, writecode, memop, pcControl, mem_rdata, mem_ack,
    input  instr_ready, mem_req, mem_we, mem_addr, mem_wdata, PC, zero_flag
  );
endinterface

// File: rtl/datapath_pipe.sv
// Multi-cycle datapath: register file, ALU, branch unit and PC, with a latched
// instruction handshake and a wait-state tolerant req/ack memory port.
module datapath_pipe #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int ADDR_W = 10,
  parameter int PC_W   = 32
) (
  input  logic            clock,
  input  logic            reset,
  datapath_pipe_if.master bus,
  output logic [1:0]      fsm_state
);
  localparam int RI  = $clog2(NREGS);
  localparam int SHW = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, MEM = 2'd2} state_t;

  state_t state, state_next;

  logic [3:0]        alucode_q;
  logic [RI-1:0]     rd_q, rs1_q, rs2_q, rs3_q;
  logic [DATA_W-1:0] imm_q;
  logic              imc_q, regen_q;
  logic [1:0]        writecode_q, memop_q;
  logic [2:0]        pcc_q;

  logic [DATA_W-1:0] regs [NREGS];

  logic [DATA_W-1:0] a, b, alu_res, sum, wb_data;
  logic [PC_W-1:0]   offset;
  logic              taken, is_mem, is_load;
  logic              accept, done_exec, start_mem, done_mem, wb_en;

  // Operands come from the live register file, so a write-back from the
  // previous instruction is already visible here.
  always_comb begin
    a       = regs[rs1_q];
    b       = imc_q ? imm_q : regs[rs2_q];
    sum     = a + b;
    offset  = PC_W'(regs[rs3_q]);
    is_load = (memop_q == 2'd1);
    is_mem  = (memop_q == 2'd1) || (memop_q == 2'd2);
  end

  always_comb begin
    alu_res = '1;
    case (alucode_q)
      4'd0:  alu_res = a;
      4'd1:  alu_res = sum;
      4'd2:  alu_res = a - b;
      4'd3:  alu_res = a * b;
      4'd4:  alu_res = (b == '0) ? '1 : a / b;
      4'd5:  alu_res = (b == '0) ? '1 : a % b;
      4'd6:  alu_res = a | b;
      4'd7:  alu_res = a & b;
      4'd8:  alu_res = a ^ b;
      4'd9:  alu_res = ~a;
      4'd10: alu_res = a >> b[SHW-1:0];
      4'd11: alu_res = a << b[SHW-1:0];
      default: alu_res = '1;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (pcc_q)
      3'd1: taken = (a == b);
      3'd2: taken = (a <  b);
      3'd3: taken = (a >  b);
      3'd4: taken = (a != b);
      3'd5: taken = (a <= b);
      3'd6: taken = (a >= b);
      3'd7: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    done_exec  = 1'b0;
    start_mem  = 1'b0;
    done_mem   = 1'b0;
    case (state)
      IDLE: if (bus.instr_valid) begin
        accept     = 1'b1;
        state_next = EXEC;
      end
      EXEC: if (is_mem) begin
        start_mem  = 1'b1;
        state_next = MEM;
      end else begin
        done_exec  = 1'b1;
        state_next = IDLE;
      end
      MEM: if (bus.mem_ack) begin
        done_mem   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    bus.instr_ready = (state == IDLE);
    fsm_state       = state;
  end

  // writecode 2 has no memory data outside a load, so it falls to all ones.
  always_comb begin
    wb_en   = 1'b0;
    wb_data = '0;
    if (done_exec && regen_q) begin
      wb_en = 1'b1;
      case (writecode_q)
        2'd0:    wb_data = alu_res;
        2'd1:    wb_data = b;
        default: wb_data = '1;
      endcase
    end else if (done_mem && is_load && regen_q) begin
      wb_en   = 1'b1;
      wb_data = bus.mem_rdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      alucode_q     <= '0;
      rd_q          <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      rs3_q         <= '0;
      imm_q         <= '0;
      imc_q         <= 1'b0;
      regen_q       <= 1'b0;
      writecode_q   <= '0;
      memop_q       <= '0;
      pcc_q         <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      bus.PC        <= '0;
      bus.zero_flag <= 1'b0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      if (accept) begin
        alucode_q   <= bus.alucode;
        rd_q        <= bus.rd;
        rs1_q       <= bus.rs1;
        rs2_q       <= bus.rs2;
        rs3_q       <= bus.rs3;
        imm_q       <= bus.imm;
        imc_q       <= bus.imControl;
        regen_q     <= bus.regenable;
        writecode_q <= bus.writecode;
        memop_q     <= bus.memop;
        pcc_q       <= bus.pcControl;
      end
      // Register 0 is never written, so it keeps reading as zero.
      if (wb_en && rd_q != '0) regs[rd_q] <= wb_data;
      if (done_exec) begin
        bus.PC        <= taken ? bus.PC + offset : bus.PC + 1'b1;
        bus.zero_flag <= (alu_res == '0);
      end
      if (start_mem) begin
        bus.mem_req   <= 1'b1;
        bus.mem_we    <= (memop_q == 2'd2);
        bus.mem_addr  <= sum[ADDR_W-1:0];
        bus.mem_wdata <= regs[rs3_q];
      end
      if (done_mem) begin
        bus.mem_req <= 1'b0;
        bus.PC      <= bus.PC + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_datapath_pipe.sv
// Directed bench for datapath_pipe: hand-computed results for ALU, branch,
// memory, reset and back-to-back issue, read back through store operations.
module tb_datapath_pipe;
  logic       clock;
  logic       reset;
  logic [1:0] fsm_state;
  int         errors = 0;
  int         checks = 0;
  logic [31:0] exp_pc;
  logic [31:0] val;

  datapath_pipe_if #(.DATA_W(32), .RI(5), .ADDR_W(10), .PC_W(32)) bus ();

  datapath_pipe #(.DATA_W(32), .NREGS(32), .ADDR_W(10), .PC_W(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_fields(input int al, input int rd, input int rs1, input int rs2,
                            input int rs3, input logic [31:0] imm, input int imc,
                            input int regen, input int wc, input int memop, input int pcc);
    bus.alucode   = 4'(al);
    bus.rd        = 5'(rd);
    bus.rs1       = 5'(rs1);
    bus.rs2       = 5'(rs2);
    bus.rs3       = 5'(rs3);
    bus.imm       = imm;
    bus.imControl = 1'(imc);
    bus.regenable = 1'(regen);
    bus.writecode = 2'(wc);
    bus.memop     = 2'(memop);
    bus.pcControl = 3'(pcc);
  endtask

  // Called #1 after a rising edge with the datapath idle; returns in EXEC.
  task automatic send(input int al, input int rd, input int rs1, input int rs2,
                      input int rs3, input logic [31:0] imm, input int imc,
                      input int regen, input int wc, input int memop, input int pcc);
    set_fields(al, rd, rs1, rs2, rs3, imm, imc, regen, wc, memop, pcc);
    bus.instr_valid = 1'b1;
    @(posedge clock); #1;
    bus.instr_valid = 1'b0;
  endtask

  task automatic op(input string tag, input int al, input int rd, input int rs1,
                    input int rs2, input int rs3, input logic [31:0] imm, input int imc,
                    input int regen, input int wc, input int pcc, input logic [31:0] step);
    send(al, rd, rs1, rs2, rs3, imm, imc, regen, wc, 0, pcc);
    check({tag, "_busy"}, 32'(bus.instr_ready), 0);
    @(posedge clock); #1;
    exp_pc = exp_pc + step;
    check({tag, "_pc"}, bus.PC, exp_pc);
  endtask

  task automatic set_reg(input int r, input logic [31:0] v);
    op("set_reg", 0, r, 0, 0, 0, v, 1, 1, 1, 0, 1);
  endtask

  // Reads a register by storing it to address 0 and capturing mem_wdata.
  task automatic read_reg(input string tag, input int r, input logic [31:0] exp);
    send(0, 0, 0, 0, r, 0, 1, 0, 0, 2, 0);
    @(posedge clock); #1;
    check({tag, "_req"}, 32'(bus.mem_req), 1);
    check(tag, bus.mem_wdata, exp);
    bus.mem_ack = 1'b1;
    @(posedge clock); #1;
    bus.mem_ack = 1'b0;
    exp_pc = exp_pc + 1;
  endtask

  initial begin
    reset = 1'b1;
    bus.instr_valid = 1'b0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    set_fields(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    exp_pc = 0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_pc", bus.PC, 0);
    check("rst_ready", 32'(bus.instr_ready), 1);
    check("rst_req", 32'(bus.mem_req), 0);
    check("rst_we", 32'(bus.mem_we), 0);
    check("rst_addr", 32'(bus.mem_addr), 0);
    check("rst_wdata", bus.mem_wdata, 0);
    check("rst_zero", 32'(bus.zero_flag), 0);
    check("rst_state", 32'(fsm_state), 0);
    reset = 1'b0;

    // r1 = 5; ALU result is A = r0 = 0, so zero_flag rises.
    set_reg(1, 5);
    check("first_ready", 32'(bus.instr_ready), 1);
    check("first_zero", 32'(bus.zero_flag), 1);
    read_reg("r1", 1, 5);

    op("div0", 4, 5, 1, 2, 0, 0, 0, 1, 0, 0, 1);
    check("div0_zero", 32'(bus.zero_flag), 0);
    read_reg("r5_div0", 5, 32'hFFFF_FFFF);
    op("mod", 5, 10, 1, 0, 0, 3, 1, 1, 0, 0, 1);
    read_reg("r10_mod", 10, 2);
    set_reg(1, 8);
    op("shr", 10, 6, 1, 0, 0, 2, 1, 1, 0, 0, 1);
    read_reg("r6_shr", 6, 2);
    op("shl_mask", 11, 6, 1, 0, 0, 33, 1, 1, 0, 0, 1);
    read_reg("r6_shl", 6, 16);
    op("sub_wrap", 2, 11, 1, 0, 0, 9, 1, 1, 0, 0, 1);
    read_reg("r11_sub", 11, 32'hFFFF_FFFF);
    op("add_zero", 1, 12, 1, 0, 0, 32'hFFFF_FFF8, 1, 1, 0, 0, 1);
    check("add_zero_flag", 32'(bus.zero_flag), 1);
    read_reg("r12_add", 12, 0);
    op("mul", 3, 13, 1, 0, 0, 32'h2000_0001, 1, 1, 0, 0, 1);
    check("mul_zero_flag", 32'(bus.zero_flag), 0);
    read_reg("r13_mul", 13, 8);
    op("xor", 8, 16, 1, 0, 0, 32'hC, 1, 1, 0, 0, 1);
    read_reg("r16_xor", 16, 4);
    op("not", 9, 16, 1, 0, 0, 0, 1, 1, 0, 0, 1);
    read_reg("r16_not", 16, 32'hFFFF_FFF7);
    op("alu13", 13, 14, 1, 0, 0, 0, 1, 1, 0, 0, 1);
    read_reg("r14_alu13", 14, 32'hFFFF_FFFF);
    op("wc2", 0, 15, 1, 0, 0, 0, 1, 1, 2, 0, 1);
    read_reg("r15_wc2", 15, 32'hFFFF_FFFF);
    set_reg(0, 77);
    read_reg("r0", 0, 0);

    // Branches with r1=3, r3=4; r2 first 3 then 4.
    set_reg(1, 3);
    set_reg(2, 3);
    set_reg(3, 4);
    op("beq_t", 0, 0, 1, 2, 3, 0, 0, 0, 0, 1, 4);
    set_reg(2, 4);
    op("beq_n", 0, 0, 1, 2, 3, 0, 0, 0, 0, 1, 1);
    op("blt_t", 0, 0, 1, 2, 3, 0, 0, 0, 0, 2, 4);
    op("bgt_n", 0, 0, 1, 2, 3, 0, 0, 0, 0, 3, 1);
    op("bne_t", 0, 0, 1, 2, 3, 0, 0, 0, 0, 4, 4);
    op("ble_t", 0, 0, 1, 2, 3, 0, 0, 0, 0, 5, 4);
    op("bge_n", 0, 0, 1, 2, 3, 0, 0, 0, 0, 6, 1);
    op("bge_imm", 0, 0, 1, 0, 3, 3, 1, 0, 0, 6, 4);
    set_reg(3, 32'hFFFF_FFFF);
    op("jmp_back", 0, 0, 1, 2, 3, 0, 0, 0, 0, 7, 32'hFFFF_FFFF);

    // Store r3=0xABCD to 8+8=0x10 with three wait states, then load it back.
    set_reg(3, 32'hABCD);
    set_reg(1, 8);
    send(0, 0, 1, 0, 3, 8, 1, 0, 0, 2, 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      check("st_req", 32'(bus.mem_req), 1);
      check("st_we", 32'(bus.mem_we), 1);
      check("st_addr", 32'(bus.mem_addr), 32'h10);
      check("st_wdata", bus.mem_wdata, 32'hABCD);
      check("st_pc_hold", bus.PC, exp_pc);
      bus.mem_ack = (i == 3);
    end
    @(posedge clock); #1;
    bus.mem_ack = 1'b0;
    exp_pc = exp_pc + 1;
    check("st_done_req", 32'(bus.mem_req), 0);
    check("st_done_pc", bus.PC, exp_pc);

    send(0, 4, 1, 0, 0, 8, 1, 1, 0, 1, 0);
    bus.mem_rdata = 32'h1234;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      check("ld_req", 32'(bus.mem_req), 1);
      check("ld_we", 32'(bus.mem_we), 0);
      check("ld_addr", 32'(bus.mem_addr), 32'h10);
      if (i == 3) bus.mem_rdata = 32'hABCD;
      bus.mem_ack = (i == 3);
    end
    @(posedge clock); #1;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    exp_pc = exp_pc + 1;
    check("ld_done_pc", bus.PC, exp_pc);
    read_reg("r4_load", 4, 32'hABCD);

    // A stray ack while idle must change nothing.
    bus.mem_ack = 1'b1;
    @(posedge clock); #1;
    bus.mem_ack = 1'b0;
    check("stray_pc", bus.PC, exp_pc);
    check("stray_state", 32'(fsm_state), 0);

    // Reset while a store waits in MEM.
    send(0, 0, 1, 0, 3, 8, 1, 0, 0, 2, 0);
    @(posedge clock); #1;
    check("mr_req_before", 32'(bus.mem_req), 1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    exp_pc = 0;
    check("mr_req", 32'(bus.mem_req), 0);
    check("mr_pc", bus.PC, 0);
    check("mr_state", 32'(fsm_state), 0);
    bus.mem_ack = 1'b1;
    @(posedge clock); #1;
    bus.mem_ack = 1'b0;
    check("mr_late_ack_pc", bus.PC, 0);
    check("mr_late_ack_req", 32'(bus.mem_req), 0);
    read_reg("r4_after_rst", 4, 0);

    // PC wrap through an offset of all ones.
    set_reg(3, 32'hFFFF_FFFF);
    op("wrap_a", 0, 0, 0, 0, 3, 0, 0, 0, 0, 7, 32'hFFFF_FFFF);
    op("wrap_b", 0, 0, 0, 0, 3, 0, 0, 0, 0, 7, 32'hFFFF_FFFF);
    check("wrap_at_zero", bus.PC, 0);
    op("wrap_c", 0, 0, 0, 0, 3, 0, 0, 0, 0, 7, 32'hFFFF_FFFF);
    op("wrap_d", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("wrap_rollover", bus.PC, 0);

    // instr_valid held high across three instructions.
    set_fields(0, 7, 0, 0, 0, 11, 1, 1, 1, 0, 0);
    bus.instr_valid = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      @(posedge clock); #1;
      check("held_state", 32'(fsm_state), (e % 2 == 1) ? 1 : 0);
      check("held_pc", bus.PC, exp_pc + 32'(e / 2));
      if (e == 1) set_fields(0, 8, 0, 0, 0, 22, 1, 1, 1, 0, 0);
      if (e == 3) set_fields(0, 9, 0, 0, 0, 33, 1, 1, 1, 0, 0);
      if (e == 5) bus.instr_valid = 1'b0;
    end
    exp_pc = exp_pc + 3;
    read_reg("r7_held", 7, 11);
    read_reg("r8_held", 8, 22);
    read_reg("r9_held", 9, 33);
    check("final_pc", bus.PC, exp_pc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
